// File: rtl/uart_tx_fifo.sv
// UART transmitter with a circular transmit FIFO; frames go out LSB-first on an idle-high line.
// Optional parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int DATA_BITS       = 8,
    parameter int STOP_BITS       = 1,
    parameter int PARITY          = 0,
    parameter int TIMER_BITS      = 32,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int LGFIFO          = 3
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              o_ready,
    output logic              o_busy,
    output logic [LGFIFO:0]   o_fill,
    output logic              uart_rxd_out
);

    localparam int                     DEPTH       = 1 << LGFIFO;
    localparam logic [TIMER_BITS-1:0]  BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam logic [TIMER_BITS-1:0]  TIMER_ONE   = TIMER_BITS'(1);
    localparam logic [TIMER_BITS-1:0]  TIMER_ZERO  = TIMER_BITS'(0);
    localparam logic [LGFIFO:0]        PTR_ONE     = (LGFIFO + 1)'(1);
    localparam logic [LGFIFO:0]        PTR_ZERO    = (LGFIFO + 1)'(0);
    localparam logic [LGFIFO:0]        PTR_MSB     = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [3:0]             LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]             LAST_STOP   = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data);
        parity_of = (^data) ^ (PARITY == 1);
    endfunction
`endif

    logic [DATA_BITS-1:0]  mem_q [DEPTH];
    logic [LGFIFO:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, fill_d;
    logic                  full_s, empty_s, push_s, pop_s, bit_end_s, frame_end_s;
    logic [DATA_BITS-1:0]  head_s;
    state_t                state_q;
    logic [TIMER_BITS-1:0] baud_q;
    logic [3:0]            bit_cnt_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  line_q, busy_q, parity_q;
    logic                  unused_s;

    // Upper data bits (for narrow characters) and PARITY (when compiled out) are intentionally dropped.
    assign unused_s = ^{i_data, 32'(PARITY)};

    assign full_s      = (wr_ptr_q ^ rd_ptr_q) == PTR_MSB;
    assign empty_s     = wr_ptr_q == rd_ptr_q;
    assign push_s      = i_valid && !full_s && !i_reset;
    assign bit_end_s   = baud_q == TIMER_ZERO;
    assign frame_end_s = (state_q == S_STOP) && bit_end_s && (bit_cnt_q == LAST_STOP);
    assign pop_s       = !empty_s && !i_reset && ((state_q == S_IDLE) || frame_end_s);
    assign head_s      = mem_q[rd_ptr_q[LGFIFO-1:0]];

    assign o_ready      = !full_s;
    assign o_busy       = busy_q;
    assign o_fill       = fill_q;
    assign uart_rxd_out = line_q;

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   fill_d = fill_q + PTR_ONE;
            2'b01:   fill_d = fill_q - PTR_ONE;
            default: fill_d = fill_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            fill_q   <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[LGFIFO-1:0]] <= i_data[DATA_BITS-1:0];
        end
    end

    // Transmit FSM; line and busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            baud_q    <= TIMER_ZERO;
            bit_cnt_q <= 4'd0;
            shift_q   <= {DATA_BITS{1'b0}};
            parity_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (pop_s) begin
                shift_q   <= head_s;
                baud_q    <= BAUD_RELOAD;
                bit_cnt_q <= 4'd0;
                line_q    <= 1'b0;
                busy_q    <= 1'b1;
                state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                parity_q  <= parity_of(head_s);
`endif
            end else begin
                line_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end else if (!bit_end_s) begin
            baud_q <= baud_q - TIMER_ONE;
        end else begin
            baud_q <= BAUD_RELOAD;
            case (state_q)
                S_START: begin
                    state_q   <= S_DATA;
                    line_q    <= shift_q[0];
                    shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_q <= 4'd0;
                end
                S_DATA: begin
                    if (bit_cnt_q != LAST_DATA) begin
                        line_q    <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end else begin
                        bit_cnt_q <= 4'd0;
`ifdef UART_TX_PARITY_EN
                        if (PARITY != 0) begin
                            state_q <= S_PARITY;
                            line_q  <= parity_q;
                        end else begin
                            state_q <= S_STOP;
                            line_q  <= 1'b1;
                        end
`else
                        state_q <= S_STOP;
                        line_q  <= 1'b1;
`endif
                    end
                end
                S_PARITY: begin
                    state_q   <= S_STOP;
                    line_q    <= 1'b1;
                    bit_cnt_q <= 4'd0;
                end
                S_STOP: begin
                    if (bit_cnt_q != LAST_STOP) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end else if (pop_s) begin
                        // Next character starts immediately, with no idle gap.
                        shift_q   <= head_s;
                        bit_cnt_q <= 4'd0;
                        line_q    <= 1'b0;
                        state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= parity_of(head_s);
`endif
                    end else begin
                        state_q <= S_IDLE;
                        line_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    line_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: single frame, back-to-back, FIFO full, reset mid-frame,
// and a 7-bit / 2-stop / even-parity instance whose expected frame follows UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst, valid, valid7;
    logic [7:0] data, data7;
    logic       ready, busy, line;
    logic [3:0] fill;
    logic       ready7, busy7, line7;
    logic [2:0] fill7;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_BITS(8), .STOP_BITS(1), .PARITY(0),
        .TIMER_BITS(16), .CLOCKS_PER_BAUD(4), .LGFIFO(3)
    ) dut (
        .clk(clk), .i_reset(rst), .i_valid(valid), .i_data(data),
        .o_ready(ready), .o_busy(busy), .o_fill(fill), .uart_rxd_out(line)
    );

    uart_tx_fifo #(
        .DATA_BITS(7), .STOP_BITS(2), .PARITY(2),
        .TIMER_BITS(8), .CLOCKS_PER_BAUD(4), .LGFIFO(2)
    ) dut7 (
        .clk(clk), .i_reset(rst), .i_valid(valid7), .i_data(data7),
        .o_ready(ready7), .o_busy(busy7), .o_fill(fill7), .uart_rxd_out(line7)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [9:0]  f1;
        logic [19:0] f2;
        logic [10:0] p_pat;
        logic [7:0]  ch;
        int          p_len;
        int          k, j, b;
        logic        exp_bit;

        f1 = 10'h2AA;
        f2 = {10'h278, 10'h34A};
`ifdef UART_TX_PARITY_EN
        p_pat = 11'h70E;
        p_len = 11;
`else
        p_pat = 11'h30E;
        p_len = 10;
`endif

        rst = 1'b1; valid = 1'b0; data = 8'h00; valid7 = 1'b0; data7 = 8'h00;
        tick; tick;
        rst = 1'b0;
        chk("rst_line",   32'(line),   32'd1);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_fill",   32'(fill),   32'd0);
        chk("rst_ready",  32'(ready),  32'd1);
        chk("rst_line7",  32'(line7),  32'd1);
        chk("rst_fill7",  32'(fill7),  32'd0);
        tick;
        chk("idle_line",  32'(line),   32'd1);

        // Single frame 0x55
        valid = 1'b1; data = 8'h55;
        tick;
        valid = 1'b0;
        chk("t1_fill_accept", 32'(fill), 32'd1);
        chk("t1_line_accept", 32'(line), 32'd1);
        chk("t1_busy_accept", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick;
            chk("t1_line", 32'(line), 32'(f1[i/4]));
            chk("t1_busy", 32'(busy), 32'd1);
        end
        tick;
        chk("t1_line_end", 32'(line), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_fill_end", 32'(fill), 32'd0);
        tick; tick;

        // Back-to-back 0xA5, 0x3C
        valid = 1'b1; data = 8'hA5;
        tick;
        chk("b2b_fill0", 32'(fill), 32'd1);
        data = 8'h3C;
        tick;
        valid = 1'b0;
        chk("b2b_fill1", 32'(fill), 32'd1);
        chk("b2b_start", 32'(line), 32'd0);
        chk("b2b_busy",  32'(busy), 32'd1);
        for (int i = 1; i < 80; i++) begin
            tick;
            chk("b2b_line", 32'(line), 32'(f2[i/4]));
            chk("b2b_busy", 32'(busy), 32'd1);
            if (i == 39) chk("b2b_fill_pre", 32'(fill), 32'd1);
            if (i == 40) chk("b2b_fill_pop", 32'(fill), 32'd0);
        end
        tick;
        chk("b2b_line_end", 32'(line), 32'd1);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        tick; tick;

        // FIFO full with i_valid held 12 cycles; data advances only on acceptance
        for (int t = 1; t <= 362; t++) begin
            if (t <= 12) begin
                valid = 1'b1;
                data  = 8'h10 + 8'((t <= 9) ? t - 1 : 8);
                chk("full_ready", 32'(ready), 32'(t <= 9));
            end else begin
                valid = 1'b0;
            end
            tick;
            if (t == 12) begin
                chk("full_fill8",  32'(fill),  32'd8);
                chk("full_ready0", 32'(ready), 32'd0);
            end
            if (t >= 2 && t <= 361) begin
                k  = t - 2;
                j  = k / 40;
                b  = (k % 40) / 4;
                ch = 8'h10 + 8'(j);
                if (b == 0)      exp_bit = 1'b0;
                else if (b == 9) exp_bit = 1'b1;
                else             exp_bit = ch[b-1];
                chk("full_line", 32'(line), 32'(exp_bit));
                chk("full_busy", 32'(busy), 32'd1);
            end
            if (t == 362) begin
                chk("full_busy_end", 32'(busy), 32'd0);
                chk("full_line_end", 32'(line), 32'd1);
                chk("full_fill_end", 32'(fill), 32'd0);
            end
        end
        tick; tick;

        // Reset during data bit 3 with bytes queued
        valid = 1'b1; data = 8'h00;
        tick; tick; tick; tick;
        valid = 1'b0;
        chk("rmf_fill_q", 32'(fill), 32'd3);
        for (int i = 0; i < 15; i++) tick;
        chk("rmf_line_bit3", 32'(line), 32'd0);
        chk("rmf_busy_bit3", 32'(busy), 32'd1);
        rst = 1'b1; valid = 1'b1; data = 8'hFF;
        tick;
        rst = 1'b0; valid = 1'b0;
        chk("rmf_line",  32'(line),  32'd1);
        chk("rmf_fill",  32'(fill),  32'd0);
        chk("rmf_busy",  32'(busy),  32'd0);
        chk("rmf_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("rmf_quiet_line", 32'(line), 32'd1);
            chk("rmf_quiet_busy", 32'(busy), 32'd0);
        end
        chk("rmf_fill_after", 32'(fill), 32'd0);

        // 7-bit, 2 stop, PARITY=2; bit 7 of the input must be ignored
        valid7 = 1'b1; data7 = 8'h87;
        tick;
        valid7 = 1'b0;
        chk("p7_fill", 32'(fill7), 32'd1);
        for (int i = 0; i < p_len * 4; i++) begin
            tick;
            chk("p7_line", 32'(line7), 32'(p_pat[i/4]));
            chk("p7_busy", 32'(busy7), 32'd1);
        end
        tick;
        chk("p7_busy_end", 32'(busy7), 32'd0);
        chk("p7_line_end", 32'(line7), 32'd1);
        chk("p7_fill_end", 32'(fill7), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
